// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
// ----------------------
// Double-buffered frame-memory controller. One single-port 16-bit SRAM is
// shared between VGA pixel reads (always win) and producer pixel writes.
// Two banks ping-pong so the display never shows a partially written frame,
// and a one-shot display start is issued once the first full frame exists.
//
// Ports
//   i_clk_25M, i_rst_n        pixel clock, async active-low reset
//   i_vga_active/addr/finish  VGA read window, pixel index, end-of-frame pulse
//   o_vga_data                pixel word to VGA (SRAM read data, passed through)
//   o_start_display           one-cycle pulse that starts the VGA engine
//   i_wr_valid/addr/data/last producer write request, last = final word of frame
//   o_wr_ready                producer write accepted when high with i_wr_valid
//   o_mem_addr/wdata/we       SRAM port, address = {bank, index}
//   i_mem_rdata               SRAM read data
//   o_disp_bank               bank currently displayed
//   o_frame_cnt               frames swapped onto the display (wraps)
//   o_addr_err                sticky: an out-of-range write was accepted
//   o_dbg_state               current scheduler state (debug)
//
// Handshake: a producer word transfers on any rising edge where
// i_wr_valid && o_wr_ready. The producer must hold addr/data/last stable
// while valid is high and ready is low; ready never depends on valid.

module frame_buffer_scheduler #(
    parameter int unsigned FRAME_WORDS = 3600
) (
    input  logic        i_clk_25M,
    input  logic        i_rst_n,
    input  logic        i_vga_active,
    input  logic [12:0] i_vga_addr,
    input  logic        i_vga_finish,
    output logic [15:0] o_vga_data,
    output logic        o_start_display,
    input  logic        i_wr_valid,
    input  logic [11:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    input  logic        i_wr_last,
    output logic        o_wr_ready,
    output logic [12:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata,
    output logic        o_disp_bank,
    output logic [7:0]  o_frame_cnt,
    output logic        o_addr_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_SHOW    = 2'd1,
        S_PENDING = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        disp_bank_q, disp_bank_d;
    logic        wr_bank_q, wr_bank_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        addr_err_q, addr_err_d;
    logic        start_q, start_d;

    logic        accept;
    logic        in_range;

    // Only index bits [11:0] address a bank; bit 12 is ignored.
    logic        unused_vga_addr_msb;
    assign unused_vga_addr_msb = i_vga_addr[12];

    assign o_wr_ready = (state_q != S_PENDING) && !i_vga_active;
    assign accept     = i_wr_valid && o_wr_ready;
    assign in_range   = (i_wr_addr < 12'(FRAME_WORDS));

    assign o_vga_data = i_mem_rdata;

    // Memory mux. The write enable is also gated by reset so a producer
    // still driving valid while reset is held cannot corrupt the SRAM.
    always_comb begin
        o_mem_addr  = {disp_bank_q, 12'd0};
        o_mem_wdata = i_wr_data;
        o_mem_we    = 1'b0;
        if (i_vga_active) begin
            o_mem_addr = {disp_bank_q, i_vga_addr[11:0]};
        end else if (accept) begin
            o_mem_addr = {wr_bank_q, i_wr_addr};
            o_mem_we   = in_range && i_rst_n;
        end
    end

    always_comb begin
        state_d     = state_q;
        disp_bank_d = disp_bank_q;
        wr_bank_d   = wr_bank_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = 1'b0;
        addr_err_d  = addr_err_q | (accept && !in_range);

        unique case (state_q)
            S_EMPTY: begin
                // First complete frame: show it and start the display once.
                if (accept && i_wr_last) begin
                    disp_bank_d = wr_bank_q;
                    wr_bank_d   = ~wr_bank_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    start_d     = 1'b1;
                    state_d     = S_SHOW;
                end
            end
            S_SHOW: begin
                // A finish arriving with the last word is too early: the swap
                // always waits for a finish seen while already pending.
                if (accept && i_wr_last) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (i_vga_finish) begin
                    disp_bank_d = wr_bank_q;
                    wr_bank_d   = disp_bank_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = S_SHOW;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_EMPTY;
            disp_bank_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            addr_err_q  <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_bank_q <= disp_bank_d;
            wr_bank_q   <= wr_bank_d;
            frame_cnt_q <= frame_cnt_d;
            addr_err_q  <= addr_err_d;
            start_q     <= start_d;
        end
    end

    assign o_start_display = start_q;
    assign o_disp_bank     = disp_bank_q;
    assign o_frame_cnt     = frame_cnt_q;
    assign o_addr_err      = addr_err_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Testbench for frame_buffer_scheduler: directed steps plus randomized
// traffic, checked every cycle against a behavioural model of the
// frame-availability rules.

module tb_frame_buffer_scheduler;

    localparam int FRAME_WORDS = 3600;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vga_active;
    logic [12:0] vga_addr;
    logic        vga_finish;
    logic [15:0] vga_data;
    logic        start_display;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        disp_bank;
    logic [7:0]  frame_cnt;
    logic        addr_err;
    logic [1:0]  dbg_state;

    frame_buffer_scheduler #(.FRAME_WORDS(FRAME_WORDS)) dut (
        .i_clk_25M       (clk),
        .i_rst_n         (rst_n),
        .i_vga_active    (vga_active),
        .i_vga_addr      (vga_addr),
        .i_vga_finish    (vga_finish),
        .o_vga_data      (vga_data),
        .o_start_display (start_display),
        .i_wr_valid      (wr_valid),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .i_wr_last       (wr_last),
        .o_wr_ready      (wr_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .o_mem_we        (mem_we),
        .i_mem_rdata     (mem_rdata),
        .o_disp_bank     (disp_bank),
        .o_frame_cnt     (frame_cnt),
        .o_addr_err      (addr_err),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    // Describes the system in terms of "has a frame been shown yet" and
    // "is a finished frame waiting for the display to reach a boundary".
    bit       m_started;
    bit       m_waiting;
    bit       m_disp;
    bit       m_wr;
    bit [7:0] m_frames;
    bit       m_err;
    bit       m_start;

    int vectors     = 0;
    int miscompares = 0;
    int starts_seen = 0;

    task automatic model_reset();
        m_started = 0;
        m_waiting = 0;
        m_disp    = 0;
        m_wr      = 0;
        m_frames  = 0;
        m_err     = 0;
        m_start   = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive at the falling edge, check the combinational
    // memory path, advance the model, check registers after the rising edge.
    task automatic cycle(input bit act, input logic [12:0] va, input bit wv,
                         input logic [11:0] wa, input logic [15:0] wd,
                         input bit wl, input bit fin, output bit acc);
        bit          exp_ready;
        bit          oor;
        logic [12:0] exp_addr;
        logic [15:0] rd;
        @(negedge clk);
        rd         = 16'($urandom);
        vga_active = act;
        vga_addr   = va;
        vga_finish = fin;
        wr_valid   = wv;
        wr_addr    = wa;
        wr_data    = wd;
        wr_last    = wl;
        mem_rdata  = rd;
        #1;
        exp_ready = !m_waiting && !act;
        acc       = wv && exp_ready;
        oor       = (int'(wa) >= FRAME_WORDS);
        if (act)      exp_addr = {m_disp, va[11:0]};
        else if (acc) exp_addr = {m_wr, wa};
        else          exp_addr = {m_disp, 12'd0};
        chk("wr_ready", wr_ready, exp_ready);
        chk("mem_we", mem_we, acc && !oor);
        chk("mem_addr", mem_addr, exp_addr);
        chk("vga_data", vga_data, rd);
        if (acc && !oor) chk("mem_wdata", mem_wdata, wd);

        m_start = 0;
        if (acc && oor) m_err = 1;
        if (!m_started) begin
            if (acc && wl) begin
                m_disp    = m_wr;
                m_wr      = !m_wr;
                m_frames  = m_frames + 1;
                m_start   = 1;
                m_started = 1;
            end
        end else if (!m_waiting) begin
            if (acc && wl) m_waiting = 1;
        end else if (fin) begin
            {m_disp, m_wr} = {m_wr, m_disp};
            m_frames  = m_frames + 1;
            m_waiting = 0;
        end

        @(posedge clk);
        #1;
        if (start_display === 1'b1) starts_seen++;
        chk("disp_bank", disp_bank, m_disp);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("addr_err", addr_err, m_err);
        chk("start_display", start_display, m_start);
    endtask

    task automatic idle(input bit fin);
        bit acc;
        cycle(0, 13'd0, 0, 12'd0, 16'd0, 0, fin, acc);
    endtask

    // Offer one word until it is accepted, with random VGA activity and
    // random finish pulses; bounded so a stuck ready cannot hang the run.
    task automatic send_word(input logic [11:0] a, input logic [15:0] d, input bit l);
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            cycle($urandom_range(0, 7) == 0, 13'($urandom_range(0, 8191)), 1,
                  a, d, l, $urandom_range(0, 15) == 0, done);
        end
        chk("wr_timeout", done, 1'b1);
    endtask

    task automatic send_frame(input int len, input bit rand_addr);
        for (int i = 0; i < len; i++) begin
            send_word(rand_addr ? 12'($urandom_range(0, 4095)) : 12'(i),
                      16'($urandom), i == len - 1);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        rst_n      = 1;
        vga_active = 0;
        vga_addr   = '0;
        vga_finish = 0;
        wr_valid   = 0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_last    = 0;
        mem_rdata  = '0;
        model_reset();
        #2;
        apply_reset();

        // Reset state, then a finish in the empty state is ignored.
        idle(0);
        idle(1);

        // First full frame: display starts, bank 0 shown, writes move to bank 1.
        send_frame(FRAME_WORDS, 0);
        idle(0);

        // VGA read has priority; the held write issues once active drops.
        cycle(1, 13'd5, 1, 12'd9, 16'hBEEF, 0, 0, acc);
        cycle(0, 13'd5, 1, 12'd9, 16'hBEEF, 0, 0, acc);
        chk("held_write_accepted", acc, 1'b1);

        // Short frame to pending: producer stalls until finish, then swap.
        send_frame(16, 0);
        repeat (3) idle(0);
        idle(1);
        cycle(0, 13'd0, 1, 12'd1, 16'h1234, 0, 0, acc);

        // Last word coincident with finish: no swap until the next finish.
        cycle(0, 13'd0, 1, 12'd2, 16'h5678, 1, 1, acc);
        idle(0);
        idle(1);

        // Out-of-range write: consumed, no SRAM write, sticky error.
        cycle(0, 13'd0, 1, 12'd3600, 16'hDEAD, 0, 0, acc);
        cycle(0, 13'd0, 1, 12'd4095, 16'hDEAD, 0, 0, acc);
        cycle(0, 13'd0, 1, 12'd3599, 16'h0F0F, 0, 0, acc);

        // Randomized frames of random length and address.
        for (int f = 0; f < 12; f++) begin
            send_frame($urandom_range(1, 40), 1);
            repeat ($urandom_range(0, 6)) idle($urandom_range(0, 3) == 0);
        end

        // One-word frames driven through enough swaps to wrap the frame count.
        for (int f = 0; f < 260; f++) begin
            cycle(0, 13'd0, 1, 12'($urandom_range(0, 3599)), 16'($urandom), 1, 0, acc);
            idle(1);
        end

        // Reach pending, then reset asynchronously mid-cycle.
        send_frame(4, 0);
        idle(0);
        @(negedge clk);
        #2;
        wr_valid   = 1;
        wr_addr    = 12'd7;
        vga_active = 0;
        rst_n      = 0;
        model_reset();
        #1;
        chk("rst_disp_bank", disp_bank, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_start", start_display, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_wr_ready_idle", wr_ready, 1'b1);
        vga_active = 1;
        #1;
        chk("rst_wr_ready_active", wr_ready, 1'b0);
        repeat (2) @(negedge clk);
        vga_active = 0;
        wr_valid   = 0;
        rst_n      = 1;

        // Second full frame after reset: exactly one more start pulse.
        idle(0);
        send_frame(FRAME_WORDS, 0);
        repeat (3) idle(1);
        chk("start_pulses", starts_seen, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Double-buffered frame-memory controller between the pixel producer (heat-map compute path) and the VGA display engine. It shares one single-port 16-bit frame SRAM between VGA pixel reads and producer writes, with VGA reads at fixed top priority. It ping-pongs two banks so the display never shows a partially written frame. It also issues the one-shot display start once the first complete frame exists.

## Interface
- FRAME_WORDS, 3600: valid pixel-index range per bank (45 rows × stride 80); indices ≥ FRAME_WORDS are out of range.
- i_clk_25M  in  1  pixel clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_vga_active  in  1  VGA engine is inside the active pixel window; i_vga_addr valid.
- i_vga_addr  in  13  VGA pixel index; bits [11:0] used.
- i_vga_finish  in  1  one-cycle end-of-frame pulse from VGA engine.
- o_vga_data  out  16  pixel word to VGA (= i_mem_rdata).
- o_start_display  out  1  one-cycle pulse that starts the VGA engine.
- i_wr_valid  in  1  producer write request.
- i_wr_addr  in  12  producer pixel index.
- i_wr_data  in  16  producer pixel value.
- i_wr_last  in  1  qualifies the final word of a frame.
- o_wr_ready  out  1  write accepted this cycle when high with i_wr_valid.
- o_mem_addr  out  13  SRAM address {bank, index[11:0]}.
- o_mem_wdata  out  16  SRAM write data.
- o_mem_we  out  1  SRAM write enable.
- i_mem_rdata  in  16  SRAM read data.
- o_disp_bank  out  1  bank currently displayed.
- o_frame_cnt  out  8  count of frames swapped onto the display, wraps 255→0.
- o_addr_err  out  1  sticky: an out-of-range write was accepted.

## Operation
- States: S_EMPTY (no complete frame, display not started), S_SHOW (display running, producer fills back bank), S_PENDING (back bank complete, waiting for frame boundary).
- Registers: state, disp_bank, wr_bank, o_frame_cnt, o_addr_err, o_start_display.
- Memory mux (combinational):
  - If i_vga_active: o_mem_addr = {disp_bank, i_vga_addr[11:0]}, o_mem_we = 0.
  - Otherwise, if a write is accepted: o_mem_addr = {wr_bank, i_wr_addr}, o_mem_wdata = i_wr_data, o_mem_we = 1 unless the index is out of range.
  - Otherwise: o_mem_addr = {disp_bank, 12'd0}, o_mem_we = 0.
- o_wr_ready = (state != S_PENDING) && !i_vga_active, combinational. VGA reads always win; the producer stalls only.
- An accept is i_wr_valid && o_wr_ready.
- Out-of-range accept (i_wr_addr ≥ FRAME_WORDS): word consumed, no SRAM write, o_addr_err sets. i_wr_last on such a word still counts.
- S_EMPTY, accepted write with i_wr_last: disp_bank ← wr_bank, wr_bank ← ~wr_bank, o_start_display pulses next cycle, o_frame_cnt +1, go to S_SHOW.
- S_SHOW, accepted write with i_wr_last: go to S_PENDING. This holds even if i_vga_finish is high the same cycle; the swap waits for the next i_vga_finish.
- S_SHOW, i_vga_finish without last: no change.
- S_PENDING, i_vga_finish: swap disp_bank ↔ wr_bank, o_frame_cnt +1, go to S_SHOW.
- o_start_display fires exactly once per reset.
- i_vga_finish in S_EMPTY is ignored.

## Timing
- Reset (async assert, sync-to-clock release): state S_EMPTY, disp_bank 0, wr_bank 0, o_frame_cnt 0, o_addr_err 0, o_start_display 0.
- o_mem_we is 0 during reset. o_wr_ready follows !i_vga_active while in reset.
- Memory outputs are combinational from inputs and state: zero-cycle address path. o_vga_data follows the SRAM's own read latency.
- Swap takes effect the cycle after the qualifying edge. The first VGA read after a swap uses the new disp_bank.
- o_start_display asserts on the cycle after the first-frame last-word accept, for 1 cycle.
- Reset mid-frame discards any partial frame. Producer must restart from index 0.

## Test plan
- After reset with i_vga_active=0: o_wr_ready=1, o_disp_bank=0, o_frame_cnt=0. Write 3600 words ending with last → o_start_display one pulse, o_disp_bank=0, o_frame_cnt=1, later writes go to address 13'h1000+idx.
- With i_vga_active=1, i_vga_addr=5, i_wr_valid=1 → o_wr_ready=0, o_mem_we=0, o_mem_addr=13'd5. Drop active → write issued next cycle with the same data held.
- In S_SHOW, write last word → o_wr_ready=0 until i_vga_finish. On finish → o_disp_bank=1, o_frame_cnt=2, o_wr_ready=1, writes target bank 0.
- In S_SHOW, last accept coincident with i_vga_finish → no swap that cycle, o_disp_bank unchanged. Next finish → swap.
- Write at i_wr_addr=3600 → o_mem_we=0, o_addr_err=1, which stays 1 through later valid frames until reset.
- Assert i_rst_n=0 in S_PENDING → all registers return to reset values immediately. A second full frame after release produces exactly one more o_start_display pulse.
